// File: rtl/branch_comparator.sv
// Branch comparator: evaluates the RISC-V branch magnitude conditions on RS1/RS2 by scanning
// CHUNK-bit slices MSB-first. Define BRCMP_EARLY_EXIT_EN to finish on the first differing slice.
module branch_comparator #(
  parameter int CHUNK = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  Funct3,
  input  logic [31:0] RS1,
  input  logic [31:0] RS2,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        zero,
  output logic        B_Flag
);
  localparam int NCHUNK = 32 / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t          state;
  logic [31:0]     a_q, b_q;
  logic [2:0]      f3_q;
  logic [IDXW-1:0] idx;
  logic            decided, eq, lt_s, lt_u;

  logic [5:0]       shamt;
  logic [CHUNK-1:0] a_c, b_c;
  logic signed [CHUNK-1:0] a_cs, b_cs;
  logic             take, last, finish;
  logic             decided_n, eq_n, lt_s_n, lt_u_n;

  function automatic logic branch_flag(input logic [2:0] f3, input logic s_lt, input logic u_lt);
    case (f3)
      3'b100:  return s_lt;
      3'b101:  return !s_lt;
      3'b110:  return u_lt;
      3'b111:  return !u_lt;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    shamt = 6'(idx) * 6'(CHUNK);
    a_c   = CHUNK'(a_q >> shamt);
    b_c   = CHUNK'(b_q >> shamt);
    a_cs  = $signed(a_c);
    b_cs  = $signed(b_c);
    take  = !decided && (a_c != b_c);
    last  = (idx == '0);
    decided_n = decided | take;
    eq_n      = take ? 1'b0 : eq;
    lt_u_n    = take ? (a_c < b_c) : lt_u;
    // A signed compare of the top slice is the unsigned compare with bit 31 inverted.
    lt_s_n    = take ? ((idx == IDX_TOP) ? (a_cs < b_cs) : (a_c < b_c)) : lt_s;
`ifdef BRCMP_EARLY_EXIT_EN
    finish = last || take;
`else
    finish = last;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      f3_q    <= '0;
      idx     <= IDX_TOP;
      decided <= 1'b0;
      eq      <= 1'b1;
      lt_s    <= 1'b0;
      lt_u    <= 1'b0;
      zero    <= 1'b0;
      B_Flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= CMP;
            a_q     <= RS1;
            b_q     <= RS2;
            f3_q    <= Funct3;
            idx     <= IDX_TOP;
            decided <= 1'b0;
            eq      <= 1'b1;
            lt_s    <= 1'b0;
            lt_u    <= 1'b0;
          end
        end
        CMP: begin
          decided <= decided_n;
          eq      <= eq_n;
          lt_s    <= lt_s_n;
          lt_u    <= lt_u_n;
          idx     <= idx - IDXW'(1);
          // Results latch from the post-update flags so the final slice is included.
          if (finish) begin
            state  <= DONE;
            zero   <= eq_n;
            B_Flag <= branch_flag(f3_q, lt_s_n, lt_u_n);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == CMP);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_branch_comparator.sv
// Bench for branch_comparator: CHUNK=8 directed and random traffic plus a CHUNK=1 back-to-back
// stream, both checked every cycle against a cycle-count/arithmetic model.
module tb_branch_comparator;
`ifdef BRCMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8, start8, ready8, busy8, done8, zero8, flag8;
  logic [2:0]  f3_8;
  logic [31:0] rs1_8, rs2_8;
  logic        rst1, start1, ready1, busy1, done1, zero1, flag1;
  logic [2:0]  f3_1;
  logic [31:0] rs1_1, rs2_1;

  branch_comparator #(.CHUNK(8)) u_c8 (
    .clk(clk), .rst_n(rst8), .start(start8), .Funct3(f3_8), .RS1(rs1_8), .RS2(rs2_8),
    .ready(ready8), .busy(busy8), .done(done8), .zero(zero8), .B_Flag(flag8));

  branch_comparator #(.CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst1), .start(start1), .Funct3(f3_1), .RS1(rs1_1), .RS2(rs2_1),
    .ready(ready1), .busy(busy1), .done(done1), .zero(zero1), .B_Flag(flag1));

  int n_chk  = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;
  bit fin1   = 1'b0;

  int   ph[2]       = '{0, 0};
  int   left[2]     = '{0, 0};
  int   acc[2]      = '{0, 0};
  int   last_acc[2] = '{-1, -1};
  int   last_lat[2] = '{0, 0};
  logic pz[2]       = '{1'b0, 1'b0};
  logic pf[2]       = '{1'b0, 1'b0};
  logic ez[2]       = '{1'b0, 1'b0};
  logic ef[2]       = '{1'b0, 1'b0};
  int   edge_n      = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    else n_pass++;
  endtask

  function automatic logic exp_flag(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return !($signed(a) < $signed(b));
      3'b110:  return a < b;
      3'b111:  return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  // Early exit stops at the slice holding the highest differing bit.
  function automatic int exp_lat(input int nch, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x;
    int p;
    x = a ^ b;
    if (!EARLY || x == 32'h0) return nch;
    p = 31;
    while (!x[p]) p--;
    return nch - p / (32 / nch);
  endfunction

  task automatic rand_ops(output logic [2:0] f, output logic [31:0] a, output logic [31:0] b);
    logic [31:0] ext[5];
    ext = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    f = 3'($urandom);
    a = $urandom;
    case ($urandom_range(3))
      0:       b = $urandom;
      1:       b = a;
      2:       b = a ^ (32'h1 << $urandom_range(31));
      default: begin a = ext[$urandom_range(4)]; b = ext[$urandom_range(4)]; end
    endcase
  endtask

  // Compare process: check outputs, then predict the state after the coming rising edge.
  initial begin
    logic o_rdy[2], o_busy[2], o_done[2], o_zero[2], o_flag[2], i_st[2], i_rst[2];
    logic [2:0]  i_f3[2];
    logic [31:0] i_a[2], i_b[2];
    string tag;
    int nch;
    forever begin
      @(negedge clk);
      o_rdy[0] = ready8; o_busy[0] = busy8; o_done[0] = done8; o_zero[0] = zero8; o_flag[0] = flag8;
      o_rdy[1] = ready1; o_busy[1] = busy1; o_done[1] = done1; o_zero[1] = zero1; o_flag[1] = flag1;
      i_st[0] = start8; i_rst[0] = rst8; i_f3[0] = f3_8; i_a[0] = rs1_8; i_b[0] = rs2_8;
      i_st[1] = start1; i_rst[1] = rst1; i_f3[1] = f3_1; i_a[1] = rs1_1; i_b[1] = rs2_1;
      for (int d = 0; d < 2; d++) begin
        tag = (d == 0) ? "c8" : "c1";
        nch = (d == 0) ? 4 : 32;
        if (mon_en) begin
          chk({tag, " ready"}, o_rdy[d], ph[d] == 0);
          chk({tag, " busy"}, o_busy[d], ph[d] == 1);
          chk({tag, " done"}, o_done[d], ph[d] == 2);
          chk({tag, " zero"}, o_zero[d], ez[d]);
          chk({tag, " B_Flag"}, o_flag[d], ef[d]);
        end
        if (!i_rst[d]) begin
          ph[d] = 0; ez[d] = 1'b0; ef[d] = 1'b0; last_acc[d] = -1;
        end else if (ph[d] == 0) begin
          if (i_st[d]) begin
            if (d == 1 && last_acc[d] >= 0)
              chk("c1 period", edge_n - last_acc[d], EARLY ? last_lat[d] + 2 : 34);
            ph[d] = 1;
            left[d] = exp_lat(nch, i_a[d], i_b[d]);
            pz[d] = (i_a[d] == i_b[d]);
            pf[d] = exp_flag(i_f3[d], i_a[d], i_b[d]);
            last_acc[d] = edge_n;
            last_lat[d] = left[d];
            acc[d]++;
          end
        end else if (ph[d] == 1) begin
          left[d]--;
          if (left[d] == 0) begin ph[d] = 2; ez[d] = pz[d]; ef[d] = pf[d]; end
        end else begin
          ph[d] = 0;
        end
      end
      edge_n++;
    end
  end

  // Called just after a rising edge; returns edges from accept until done is seen.
  task automatic run8(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, output int lat);
    int w;
    w = 0;
    while (!ready8 && w < 50) begin @(posedge clk); #1; w++; end
    start8 = 1'b1; f3_8 = f; rs1_8 = a; rs2_8 = b;
    @(posedge clk); #1;
    start8 = 1'b0; f3_8 = 3'($urandom); rs1_8 = $urandom; rs2_8 = $urandom;
    lat = 0;
    while (lat < 50) begin
      @(posedge clk); #1; lat++;
      if (done8) break;
    end
  endtask

  // CHUNK=1 stream: start held high, fresh random operands every cycle.
  initial begin
    int cyc;
    cyc = 0;
    rst1 = 1'b0; start1 = 1'b0; f3_1 = '0; rs1_1 = '0; rs2_1 = '0;
    repeat (2) @(posedge clk);
    #1 rst1 = 1'b1; start1 = 1'b1;
    while (acc[1] < 1000 && cyc < 40000) begin
      rand_ops(f3_1, rs1_1, rs2_1);
      @(posedge clk); #1; cyc++;
    end
    start1 = 1'b0;
    fin1 = 1'b1;
  end

  initial begin
    int lat, n;
    rst8 = 1'b0; start8 = 1'b0; f3_8 = '0; rs1_8 = '0; rs2_8 = '0;
    repeat (2) @(posedge clk);
    #1 rst8 = 1'b1; mon_en = 1'b1;
    chk("reset ready", ready8, 1'b1);
    chk("reset done", done8, 1'b0);
    chk("reset zero", zero8, 1'b0);
    chk("reset B_Flag", flag8, 1'b0);

    run8(3'b000, 32'h1234_5678, 32'h1234_5678, lat);
    chk("eq lat", lat, 4);
    chk("eq zero", zero8, 1'b1);
    chk("eq B_Flag", flag8, 1'b0);

    run8(3'b100, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    chk("blt lat", lat, EARLY ? 1 : 4);
    chk("blt zero", zero8, 1'b0);
    chk("blt B_Flag", flag8, 1'b1);

    run8(3'b110, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    chk("bltu B_Flag", flag8, 1'b0);

    run8(3'b111, 32'h8000_0000, 32'h7FFF_FFFF, lat);
    chk("bgeu lat", lat, EARLY ? 1 : 4);
    chk("bgeu B_Flag", flag8, 1'b1);

    run8(3'b101, 32'h0000_0001, 32'h0000_0000, lat);
    chk("bge lat", lat, 4);
    chk("bge zero", zero8, 1'b0);
    chk("bge B_Flag", flag8, 1'b1);

    for (int k = 0; k < 3; k++) begin
      f3_8 = 3'($urandom);
      @(posedge clk); #1;
      chk("hold B_Flag", flag8, 1'b1);
      chk("hold zero", zero8, 1'b0);
    end

    // Start held through CMP with new operands: first result stands, re-accept at edge 6.
    start8 = 1'b1; f3_8 = 3'b110; rs1_8 = 32'd5; rs2_8 = 32'd9;
    @(posedge clk); #1;
    rs1_8 = '0; rs2_8 = '0; f3_8 = 3'b000;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 4) begin
        chk("held done", done8, 1'b1);
        chk("held zero", zero8, 1'b0);
        chk("held B_Flag", flag8, 1'b1);
      end
      if (k == 5) chk("held ready", ready8, 1'b1);
      if (k == 6) chk("held reaccept", busy8, 1'b1);
    end
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 50) begin @(posedge clk); #1; n++; end
    chk("second zero", zero8, 1'b1);
    chk("second B_Flag", flag8, 1'b0);

    // Reset on the second CMP edge aborts the operation.
    @(posedge clk); #1;
    start8 = 1'b1; f3_8 = 3'b000; rs1_8 = 32'h100; rs2_8 = 32'h100;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    rst8 = 1'b0;
    @(posedge clk); #1;
    rst8 = 1'b1;
    chk("abort ready", ready8, 1'b1);
    chk("abort done", done8, 1'b0);
    chk("abort zero", zero8, 1'b0);
    chk("abort B_Flag", flag8, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("abort no done", done8, 1'b0);
    end

    for (int k = 0; k < 3000; k++) begin
      start8 = ($urandom_range(2) != 0);
      rst8 = ($urandom_range(199) != 0);
      rand_ops(f3_8, rs1_8, rs2_8);
      @(posedge clk); #1;
    end
    start8 = 1'b0; rst8 = 1'b1;

    n = 0;
    while (!fin1 && n < 60000) begin @(posedge clk); #1; n++; end
    chk("c1 stream finished", fin1, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
